// File: rtl/gcd_lcm_seq.sv
// rtl/gcd_lcm_seq.sv - iterative GCD/LCM coprocessor sequencer
//
// Purpose: captures two unsigned operands on an accepted start. It then runs a
// subtractive GCD loop or an additive LCM loop, one step per cycle, and presents
// a registered result for coprocessor write-back.
//
// Ports:
//   clk      - clock, all state updates on the rising edge
//   reset    - synchronous active-high reset
//   start    - launch request, accepted only in IDLE or DONE
//   lcm_sel  - operation select at start: 0 = GCD, 1 = LCM
//   src_a    - operand A, captured at accepted start
//   src_b    - operand B, captured at accepted start
//   busy     - core stall request, high in CHECK / GCD_RUN / LCM_RUN
//   done     - one-cycle pulse, result and err valid
//   result   - registered result, held until the next completion or reset
//   err      - registered overflow / iteration-timeout flag, held with result

module gcd_lcm_seq #(
    parameter int WIDTH    = 32,
    parameter int MAX_ITER = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             lcm_sel,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             err
);

    localparam int CW = (MAX_ITER > 2) ? $clog2(MAX_ITER) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_GCD_RUN,
        S_LCM_RUN,
        S_DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] n;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             op;
    logic [CW-1:0]    count;

    // Sums are one bit wider so an LCM step that leaves the range shows up as a carry.
    logic [WIDTH:0]   m_sum;
    logic [WIDTH:0]   n_sum;
    logic             last_iter;
    logic             accept;

    assign m_sum     = {1'b0, m} + {1'b0, a};
    assign n_sum     = {1'b0, n} + {1'b0, b};
    assign last_iter = (count == CW'(MAX_ITER - 1));
    assign accept    = start && ((state == S_IDLE) || (state == S_DONE));

    assign busy = (state == S_CHECK) || (state == S_GCD_RUN) || (state == S_LCM_RUN);
    assign done = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            m      <= '0;
            n      <= '0;
            a      <= '0;
            b      <= '0;
            op     <= 1'b0;
            count  <= '0;
            result <= '0;
            err    <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        a     <= src_a;
                        b     <= src_b;
                        m     <= src_a;
                        n     <= src_b;
                        op    <= lcm_sel;
                        count <= '0;
                        err   <= 1'b0;
                        state <= S_CHECK;
                    end else begin
                        state <= S_IDLE;
                    end
                end

                // Zero operands never converge in either loop, so they are resolved here.
                S_CHECK: begin
                    if (!op) begin
                        if (a == '0) begin
                            result <= b;
                            state  <= S_DONE;
                        end else if (b == '0) begin
                            result <= a;
                            state  <= S_DONE;
                        end else begin
                            state <= S_GCD_RUN;
                        end
                    end else begin
                        if ((a == '0) || (b == '0)) begin
                            result <= '0;
                            state  <= S_DONE;
                        end else begin
                            state <= S_LCM_RUN;
                        end
                    end
                end

                S_GCD_RUN: begin
                    count <= count + 1'b1;
                    if (m == n) begin
                        result <= m;
                        state  <= S_DONE;
                    end else if (last_iter) begin
                        result <= '0;
                        err    <= 1'b1;
                        state  <= S_DONE;
                    end else if (m > n) begin
                        m <= m - n;
                    end else begin
                        n <= n - m;
                    end
                end

                // Both multiples grow toward the LCM; the smaller one takes the step.
                S_LCM_RUN: begin
                    count <= count + 1'b1;
                    if (m == n) begin
                        result <= m;
                        state  <= S_DONE;
                    end else if (last_iter) begin
                        result <= '0;
                        err    <= 1'b1;
                        state  <= S_DONE;
                    end else if (m < n) begin
                        if (m_sum[WIDTH]) begin
                            result <= '0;
                            err    <= 1'b1;
                            state  <= S_DONE;
                        end else begin
                            m <= m_sum[WIDTH-1:0];
                        end
                    end else begin
                        if (n_sum[WIDTH]) begin
                            result <= '0;
                            err    <= 1'b1;
                            state  <= S_DONE;
                        end else begin
                            n <= n_sum[WIDTH-1:0];
                        end
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_lcm_seq.sv
// tb/tb_gcd_lcm_seq.sv - scoreboard bench for gcd_lcm_seq (32-bit and 8-bit/16-iteration instances)

module tb_gcd_lcm_seq;

    logic        clk = 1'b0;
    logic        reset;

    logic        start;
    logic        lcm_sel;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        err;

    logic        start8;
    logic        lcm_sel8;
    logic [7:0]  src_a8;
    logic [7:0]  src_b8;
    logic        busy8;
    logic        done8;
    logic [7:0]  result8;
    logic        err8;

    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] res;
        logic        err;
        int          acc;
        int          lat;
        string       tag;
    } exp_t;

    exp_t q32[$];
    exp_t q8[$];
    exp_t e32;
    exp_t e8;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gcd_lcm_seq #(.WIDTH(32), .MAX_ITER(1024)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .lcm_sel (lcm_sel),
        .src_a   (src_a),
        .src_b   (src_b),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .err     (err)
    );

    gcd_lcm_seq #(.WIDTH(8), .MAX_ITER(16)) dut8 (
        .clk     (clk),
        .reset   (reset),
        .start   (start8),
        .lcm_sel (lcm_sel8),
        .src_a   (src_a8),
        .src_b   (src_b8),
        .busy    (busy8),
        .done    (done8),
        .result  (result8),
        .err     (err8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: Euclid by remainder, LCM by a/g*b with a range test.
    function automatic exp_t model(input logic sel, input logic [31:0] a, input logic [31:0] b,
                                   input int lat, input int acc, input string tag);
        exp_t e;
        longint unsigned x, y, t, l;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        e.res = '0;
        e.err = 1'b0;
        if (!sel) begin
            e.res = x[31:0];
        end else if (a != 0 && b != 0) begin
            l = (a / x) * b;
            if (l > 64'hFFFF_FFFF) e.err = 1'b1;
            else                   e.res = l[31:0];
        end
        e.acc = acc;
        e.lat = lat;
        e.tag = tag;
        return e;
    endfunction

    // Called at a falling edge; returns at the falling edge of the CHECK cycle.
    task automatic launch32(input logic sel, input logic [31:0] a, input logic [31:0] b,
                            input int lat, input string tag, input bit expect_done = 1'b1);
        start   = 1'b1;
        lcm_sel = sel;
        src_a   = a;
        src_b   = b;
        if (expect_done) q32.push_back(model(sel, a, b, lat, cyc, tag));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic launch8(input logic sel, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] res, input logic e, input int lat, input string tag);
        exp_t x;
        start8   = 1'b1;
        lcm_sel8 = sel;
        src_a8   = a;
        src_b8   = b;
        x.res = {24'd0, res};
        x.err = e;
        x.acc = cyc;
        x.lat = lat;
        x.tag = tag;
        q8.push_back(x);
        @(negedge clk);
        start8 = 1'b0;
    endtask

    task automatic drain(input int budget);
        int t = 0;
        while ((q32.size() != 0 || q8.size() != 0) && t < budget) begin
            @(negedge clk);
            t++;
        end
        if (t >= budget) check("drain_timeout", 64'(q32.size() + q8.size()), 64'd0);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (done) begin
            if (q32.size() == 0) begin
                check("unexpected_done32", 64'd1, 64'd0);
            end else begin
                e32 = q32.pop_front();
                check({e32.tag, "_result"}, 64'(result), 64'(e32.res));
                check({e32.tag, "_err"}, 64'(err), 64'(e32.err));
                if (e32.lat >= 0) check({e32.tag, "_latency"}, 64'(cyc - e32.acc), 64'(e32.lat));
            end
        end
        if (done8) begin
            if (q8.size() == 0) begin
                check("unexpected_done8", 64'd1, 64'd0);
            end else begin
                e8 = q8.pop_front();
                check({e8.tag, "_result"}, 64'(result8), 64'(e8.res[7:0]));
                check({e8.tag, "_err"}, 64'(err8), 64'(e8.err));
                if (e8.lat >= 0) check({e8.tag, "_latency"}, 64'(cyc - e8.acc), 64'(e8.lat));
            end
        end
    end

    initial begin
        int t;
        reset = 1'b1;
        start = 1'b0; lcm_sel = 1'b0; src_a = '0; src_b = '0;
        start8 = 1'b0; lcm_sel8 = 1'b0; src_a8 = '0; src_b8 = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_result", 64'(result), 64'd0);
        check("reset_err", 64'(err), 64'd0);
        check("reset_busy8", 64'(busy8), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // GCD(12,8): busy T1..T4, done T5; a start during T2 must be ignored.
        launch32(1'b0, 32'd12, 32'd8, 5, "gcd_12_8");
        for (int i = 1; i <= 4; i++) begin
            check("gcd_12_8_busy", 64'(busy), 64'd1);
            if (i == 2) begin
                start = 1'b1; lcm_sel = 1'b1; src_a = 32'd100; src_b = 32'd7;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        drain(50);

        launch32(1'b0, 32'd0, 32'd9, 2, "gcd_0_9");   drain(20);
        launch32(1'b0, 32'd9, 32'd0, 2, "gcd_9_0");   drain(20);
        launch32(1'b0, 32'd0, 32'd0, 2, "gcd_0_0");   drain(20);
        launch32(1'b1, 32'd7, 32'd0, 2, "lcm_7_0");   drain(20);
        launch32(1'b1, 32'd4, 32'd6, 6, "lcm_4_6");   drain(20);
        launch32(1'b1, 32'd5, 32'd5, 3, "lcm_5_5");   drain(20);

        // Back-to-back: second start issued in the DONE cycle of the first.
        launch32(1'b0, 32'd18, 32'd12, 5, "b2b_gcd");
        t = 0;
        while (!done && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("b2b_first_done", 64'(done), 64'd1);
        check("b2b_busy_in_done", 64'(busy), 64'd0);
        launch32(1'b1, 32'd3, 32'd4, 8, "b2b_lcm");
        check("b2b_busy_after", 64'(busy), 64'd1);
        t = 0;
        while (!done && t < 50) begin
            check("b2b_result_hold", 64'(result), 64'd6);
            @(negedge clk);
            t++;
        end
        check("b2b_second_done", 64'(done), 64'd1);
        drain(50);

        for (int i = 0; i < 20; i++) begin
            launch32(1'($urandom_range(0, 1)), 32'($urandom_range(0, 40)),
                     32'($urandom_range(0, 40)), -1, "rand");
            drain(600);
        end

        // 8-bit, 16-iteration instance: overflow, exact-fit, and the iteration boundary.
        launch8(1'b1, 8'd255, 8'd254, 8'd0, 1'b1, 3, "lcm8_ovf");    drain(50);
        launch8(1'b1, 8'd255, 8'd255, 8'd255, 1'b0, 3, "lcm8_max"); drain(50);
        launch8(1'b1, 8'd5, 8'd3, 8'd15, 1'b0, 9, "lcm8_5_3");      drain(50);
        launch8(1'b0, 8'd16, 8'd1, 8'd1, 1'b0, 18, "gcd8_last");    drain(50);
        launch8(1'b0, 8'd17, 8'd1, 8'd0, 1'b1, 18, "gcd8_tmo17");   drain(50);
        launch8(1'b0, 8'd200, 8'd1, 8'd0, 1'b1, 18, "gcd8_tmo200"); drain(50);

        // Reset mid-run discards the operation and clears held result/err.
        launch32(1'b1, 32'd6, 32'd4, -1, "pre_reset");
        drain(50);
        check("pre_reset_result", 64'(result), 64'd12);
        launch32(1'b0, 32'd1000, 32'd1, 0, "rst_run", 1'b0);
        repeat (2) @(negedge clk);
        check("rst_busy_before", 64'(busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_err8", 64'(err8), 64'd0);
        repeat (30) @(negedge clk);
        check("rst_still_idle", 64'(busy), 64'd0);
        check("sb_empty", 64'(q32.size() + q8.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
